// File: rtl/apb_mig_pkg.sv
// Shared types and constants for the APB to MIG native UI bridge.
package apb_mig_pkg;

    localparam int LANES = 4;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    typedef logic [31:0]  apb_addr_t;
    typedef logic [31:0]  data_t;
    typedef logic [3:0]   strb_t;
    typedef logic [27:0]  mig_addr_t;
    typedef logic [127:0] mig_data_t;
    typedef logic [15:0]  mig_mask_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/apb_mig_lane.sv
// Lane steering between one 32-bit APB word and the 128-bit MIG data word:
// write replication, per-lane byte mask, and read lane selection.
module apb_mig_lane
    import apb_mig_pkg::*;
(
    input  logic [1:0] lane_i,
    input  data_t      wdata_i,
    input  strb_t      strb_i,
    input  mig_data_t  rd_data_i,
    output mig_data_t  wdf_data_o,
    output mig_mask_t  wdf_mask_o,
    output data_t      rd_word_o
);

    // Every lane carries the same word; only the mask decides which bytes land.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wdf_data_o[gi*32 +: 32] = wdata_i;
            assign wdf_mask_o[gi*4 +: 4]   = (lane_i == 2'(gi)) ? ~strb_i : 4'hF;
        end
    endgenerate

    assign rd_word_o = rd_data_i[lane_i*32 +: 32];

endmodule

// File: rtl/apb_mig_bridge.sv
// APB completer issuing one MIG native UI command per APB transfer.
// Optional macro APB_MIG_TIMEOUT_EN bounds the wait on the MIG.
module apb_mig_bridge
    import apb_mig_pkg::*;
#(
    parameter int APB_ADDR_W     = 32,
    parameter int DATA_W         = 32,
    parameter int MIG_ADDR_W     = 28,
    parameter int MIG_DATA_W     = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic [APB_ADDR_W-1:0]   paddr_i,
    input  logic [DATA_W-1:0]       pwdata_i,
    input  logic                    pwrite_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic [DATA_W/8-1:0]     pstrb_i,
    output logic [DATA_W-1:0]       prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    input  logic                    init_calib_complete_i,
    output logic [MIG_ADDR_W-1:0]   app_addr_o,
    output logic [2:0]              app_cmd_o,
    output logic                    app_en_o,
    input  logic                    app_rdy_i,
    output logic [MIG_DATA_W-1:0]   app_wdf_data_o,
    output logic [MIG_DATA_W/8-1:0] app_wdf_mask_o,
    output logic                    app_wdf_wren_o,
    output logic                    app_wdf_end_o,
    input  logic                    app_wdf_rdy_i,
    input  logic [MIG_DATA_W-1:0]   app_rd_data_i,
    input  logic                    app_rd_data_valid_i
);

    state_e                    state_q;
    logic [1:0]                lane_q;
    logic [MIG_ADDR_W-1:0]     app_addr_q;
    logic [2:0]                app_cmd_q;
    logic                      app_en_q;
    logic                      app_wdf_wren_q;
    logic [MIG_DATA_W-1:0]     app_wdf_data_q;
    logic [MIG_DATA_W/8-1:0]   app_wdf_mask_q;
    logic [DATA_W-1:0]         prdata_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic                      cmd_done_q;
    logic                      wd_done_q;
    logic                      cmd_done_d;
    logic                      wd_done_d;
    logic                      tmo_hit;

    logic [1:0]  lane_sel;
    mig_data_t   lane_wdf_data;
    mig_mask_t   lane_wdf_mask;
    data_t       lane_rd_word;
    logic        access;
    logic        req_error;
    logic        busy;

    // In IDLE the lane comes straight from the bus so write data/mask can be
    // registered on the capture edge; afterwards the captured lane is used.
    assign lane_sel  = (state_q == ST_IDLE) ? paddr_i[3:2] : lane_q;
    assign access    = psel_i && penable_i;
    assign req_error = !init_calib_complete_i || (paddr_i[1:0] != 2'b00);
    assign busy      = (state_q == ST_WR) || (state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT);

    apb_mig_lane u_lane (
        .lane_i     (lane_sel),
        .wdata_i    (pwdata_i),
        .strb_i     (pstrb_i),
        .rd_data_i  (app_rd_data_i),
        .wdf_data_o (lane_wdf_data),
        .wdf_mask_o (lane_wdf_mask),
        .rd_word_o  (lane_rd_word)
    );

`ifdef APB_MIG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge pclk_i) begin
        if (preset_i || state_q == ST_IDLE) begin
            tmo_cnt_q <= '0;
        end else if (busy) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign tmo_hit = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign tmo_hit        = 1'b0;
`endif

    // Command and write-data handshakes complete independently; the completing
    // cycle itself counts toward leaving WR.
    always_comb begin
        cmd_done_d = cmd_done_q | (app_en_q & app_rdy_i);
        wd_done_d  = wd_done_q | (app_wdf_wren_q & app_wdf_rdy_i);
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q        <= ST_IDLE;
            lane_q         <= '0;
            app_addr_q     <= '0;
            app_cmd_q      <= '0;
            app_en_q       <= 1'b0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_data_q <= '0;
            app_wdf_mask_q <= '0;
            prdata_q       <= '0;
            pready_q       <= 1'b0;
            pslverr_q      <= 1'b0;
            cmd_done_q     <= 1'b0;
            wd_done_q      <= 1'b0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            if (tmo_hit) begin
                state_q        <= ST_RESP;
                pready_q       <= 1'b1;
                pslverr_q      <= 1'b1;
                app_en_q       <= 1'b0;
                app_wdf_wren_q <= 1'b0;
                cmd_done_q     <= 1'b0;
                wd_done_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (access) begin
                            if (req_error) begin
                                state_q   <= ST_RESP;
                                pready_q  <= 1'b1;
                                pslverr_q <= 1'b1;
                            end else begin
                                lane_q     <= paddr_i[3:2];
                                app_addr_q <= {paddr_i[MIG_ADDR_W:4], 3'b000};
                                app_en_q   <= 1'b1;
                                if (pwrite_i) begin
                                    state_q        <= ST_WR;
                                    app_cmd_q      <= MIG_CMD_WRITE;
                                    app_wdf_wren_q <= 1'b1;
                                    app_wdf_data_q <= lane_wdf_data;
                                    app_wdf_mask_q <= lane_wdf_mask;
                                end else begin
                                    state_q   <= ST_RD_CMD;
                                    app_cmd_q <= MIG_CMD_READ;
                                end
                            end
                        end
                    end
                    ST_WR: begin
                        app_en_q       <= app_en_q & ~app_rdy_i;
                        app_wdf_wren_q <= app_wdf_wren_q & ~app_wdf_rdy_i;
                        if (cmd_done_d && wd_done_d) begin
                            state_q    <= ST_RESP;
                            pready_q   <= 1'b1;
                            cmd_done_q <= 1'b0;
                            wd_done_q  <= 1'b0;
                        end else begin
                            cmd_done_q <= cmd_done_d;
                            wd_done_q  <= wd_done_d;
                        end
                    end
                    ST_RD_CMD: begin
                        if (app_rdy_i) begin
                            app_en_q <= 1'b0;
                            state_q  <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (app_rd_data_valid_i) begin
                            prdata_q <= lane_rd_word;
                            pready_q <= 1'b1;
                            state_q  <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign prdata_o       = prdata_q;
    assign pready_o       = pready_q;
    assign pslverr_o      = pslverr_q;
    assign app_addr_o     = app_addr_q;
    assign app_cmd_o      = app_cmd_q;
    assign app_en_o       = app_en_q;
    assign app_wdf_data_o = app_wdf_data_q;
    assign app_wdf_mask_o = app_wdf_mask_q;
    assign app_wdf_wren_o = app_wdf_wren_q;
    assign app_wdf_end_o  = app_wdf_wren_q;

    logic unused_paddr;
    assign unused_paddr = ^paddr_i[APB_ADDR_W-1:MIG_ADDR_W+1];

    // The requester must hold the access phase until pready.
    a_hold_access: assert property (@(posedge pclk_i) disable iff (preset_i)
        busy |-> access);
    a_err_with_ready: assert property (@(posedge pclk_i) disable iff (preset_i)
        pslverr_o |-> pready_o);

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Self-checking bench for apb_mig_bridge: directed table, reset abort, random traffic.
`timescale 1ns/1ps
module tb_apb_mig_bridge;

    localparam int TMO = 16;

    logic         pclk_i = 1'b0;
    logic         preset_i;
    logic [31:0]  paddr_i;
    logic [31:0]  pwdata_i;
    logic         pwrite_i;
    logic         psel_i;
    logic         penable_i;
    logic [3:0]   pstrb_i;
    logic [31:0]  prdata_o;
    logic         pready_o;
    logic         pslverr_o;
    logic         init_calib_complete_i;
    logic [27:0]  app_addr_o;
    logic [2:0]   app_cmd_o;
    logic         app_en_o;
    logic         app_rdy_i;
    logic [127:0] app_wdf_data_o;
    logic [15:0]  app_wdf_mask_o;
    logic         app_wdf_wren_o;
    logic         app_wdf_end_o;
    logic         app_wdf_rdy_i;
    logic [127:0] app_rd_data_i;
    logic         app_rd_data_valid_i;

    always #5 pclk_i = ~pclk_i;

    apb_mig_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .pclk_i                (pclk_i),
        .preset_i              (preset_i),
        .paddr_i               (paddr_i),
        .pwdata_i              (pwdata_i),
        .pwrite_i              (pwrite_i),
        .psel_i                (psel_i),
        .penable_i             (penable_i),
        .pstrb_i               (pstrb_i),
        .prdata_o              (prdata_o),
        .pready_o              (pready_o),
        .pslverr_o             (pslverr_o),
        .init_calib_complete_i (init_calib_complete_i),
        .app_addr_o            (app_addr_o),
        .app_cmd_o             (app_cmd_o),
        .app_en_o              (app_en_o),
        .app_rdy_i             (app_rdy_i),
        .app_wdf_data_o        (app_wdf_data_o),
        .app_wdf_mask_o        (app_wdf_mask_o),
        .app_wdf_wren_o        (app_wdf_wren_o),
        .app_wdf_end_o         (app_wdf_end_o),
        .app_wdf_rdy_i         (app_wdf_rdy_i),
        .app_rd_data_i         (app_rd_data_i),
        .app_rd_data_valid_i   (app_rd_data_valid_i)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        calib;
        int          cmd_rdy;
        int          wdf_rdy;
        int          rd_dly;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference state: byte-addressed APB view and the DRAM contents seen by the MIG.
    logic [7:0]   apb_mem [int unsigned];
    logic [127:0] mig_mem [int unsigned];
    logic [31:0]  prdata_exp = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk_i);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            int unsigned ba;
            ba = {a[31:2], 2'(b)};
            if (apb_mem.exists(ba)) w[b*8 +: 8] = apb_mem[ba];
        end
        return w;
    endfunction

    function automatic logic [27:0] model_mig_addr(input logic [31:0] a);
        logic [31:0] t;
        t = (a >> 4) << 3;
        return t[27:0];
    endfunction

    function automatic logic [15:0] model_mask(input logic [31:0] a, input logic [3:0] s);
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = !(((i / 4) == int'(a[3:2])) && s[i % 4]);
        return m;
    endfunction

    function automatic int at_least_1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int model_lat(input logic wr, input logic err, input int c, input int w, input int d);
        if (err) return 1;
        if (wr) return ((at_least_1(c) > at_least_1(w)) ? at_least_1(c) : at_least_1(w)) + 1;
        return at_least_1(c) + d + 1;
    endfunction

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic calib, input int cmd_rdy,
                            input int wdf_rdy, input int rd_dly, input logic exp_err, input int exp_lat);
        int n = 0;
        int got_lat = -1;
        logic got_err = 1'b0;
        logic [31:0] got_prdata = '0;
        int h_cmd = -1;
        int h_wd = -1;
        int en_seen = 0, wren_seen = 0, after_hs = 0, proto_bad = 0;
        logic cap_cmd_v = 1'b0, cap_wd_v = 1'b0;
        logic [27:0]  cap_addr = '0;
        logic [2:0]   cap_cmd = '0;
        logic [127:0] cap_data = '0;
        logic [15:0]  cap_mask = '0;
        logic issue;
        int v_cyc;
        issue = calib && (addr[1:0] == 2'b00);
        v_cyc = at_least_1(cmd_rdy) + rd_dly;

        init_calib_complete_i = calib;
        paddr_i   = addr;
        pwdata_i  = wdata;
        pstrb_i   = strb;
        pwrite_i  = wr;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        step();
        penable_i = 1'b1;
        forever begin
            app_rdy_i     = (n >= cmd_rdy);
            app_wdf_rdy_i = (n >= wdf_rdy);
            if (!wr) begin
                app_rd_data_valid_i = (n == v_cyc);
                if (n == v_cyc)
                    app_rd_data_i = mig_mem.exists(cap_addr) ? mig_mem[cap_addr] : '0;
                else
                    app_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                app_rd_data_valid_i = 1'($urandom % 2);
                app_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
            end
            if (app_wdf_end_o !== app_wdf_wren_o) proto_bad++;
            if (pslverr_o && !pready_o) proto_bad++;
            if (app_en_o) begin
                en_seen++;
                if (h_cmd >= 0) after_hs++;
                if (!cap_cmd_v) begin
                    cap_cmd_v = 1'b1;
                    cap_addr = app_addr_o;
                    cap_cmd = app_cmd_o;
                end
                if (app_rdy_i) h_cmd = n;
            end
            if (app_wdf_wren_o) begin
                wren_seen++;
                if (h_wd >= 0) after_hs++;
                if (!cap_wd_v) begin
                    cap_wd_v = 1'b1;
                    cap_data = app_wdf_data_o;
                    cap_mask = app_wdf_mask_o;
                end
                if (app_wdf_rdy_i) h_wd = n;
            end
            if (pready_o) begin
                got_lat = n;
                got_err = pslverr_o;
                got_prdata = prdata_o;
                break;
            end
            if (n >= 60) begin
                n_checks++;
                n_fail++;
                $display("FAIL pready_timeout: got no pready after %0d cycles required cycle %0d", n, exp_lat);
                break;
            end
            step();
            n++;
        end

        if (wr && h_cmd >= 0 && h_wd >= 0) begin
            logic [127:0] word;
            word = mig_mem.exists(cap_addr) ? mig_mem[cap_addr] : '0;
            for (int i = 0; i < 16; i++)
                if (!cap_mask[i]) word[i*8 +: 8] = cap_data[i*8 +: 8];
            mig_mem[cap_addr] = word;
        end

        step();
        check("pready_one_cycle", pready_o, 1'b0);
        psel_i = 1'b0;
        penable_i = 1'b0;
        app_rdy_i = 1'b0;
        app_wdf_rdy_i = 1'b0;
        app_rd_data_valid_i = 1'b0;

        check("latency", got_lat, exp_lat);
        check("pslverr", got_err, exp_err);
        check("protocol", proto_bad, 0);
        if (issue) begin
            check("app_addr", cap_addr, model_mig_addr(addr));
            check("app_cmd", cap_cmd, wr ? 3'b000 : 3'b001);
            check("enable_drop", after_hs, 0);
            if (wr) begin
                check("wdf_data", cap_data, {4{wdata}});
                check("wdf_mask", cap_mask, model_mask(addr, strb));
            end else begin
                check("no_wren_on_read", wren_seen, 0);
            end
        end else begin
            check("no_mig_traffic", en_seen + wren_seen, 0);
        end
        if (!exp_err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) apb_mem[{addr[31:2], 2'(b)}] = wdata[b*8 +: 8];
            end else begin
                prdata_exp = model_read(addr);
            end
        end
        check("prdata", got_prdata, prdata_exp);
        n_txn++;
        $display("txn %0d %s addr=%08h lat=%0d err=%0b prdata=%08h", n_txn, wr ? "WR" : "RD",
                 addr, got_lat, got_err, got_prdata);
    endtask

    vec_t tbl [9];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        preset_i = 1'b1;
        paddr_i = '0;
        pwdata_i = '0;
        pwrite_i = 1'b0;
        psel_i = 1'b0;
        penable_i = 1'b0;
        pstrb_i = '0;
        init_calib_complete_i = 1'b1;
        app_rdy_i = 1'b0;
        app_wdf_rdy_i = 1'b0;
        app_rd_data_i = '0;
        app_rd_data_valid_i = 1'b0;
        step();
        step();
        check("reset_outputs", {pready_o, pslverr_o, app_en_o, app_wdf_wren_o, app_wdf_end_o,
                                app_cmd_o, app_addr_o, prdata_o, app_wdf_mask_o}, '0);
        check("reset_wdf_data", app_wdf_data_o, '0);
        preset_i = 1'b0;
        step();

        //            wr    addr         wdata         strb   cal  crdy wrdy dly err lat
        tbl[0] = '{1'b1, 32'h104, 32'hDEADBEEF, 4'hF,  1'b1, 1,   1,   0,  1'b0, 2};
        tbl[1] = '{1'b1, 32'h10C, 32'h12345678, 4'hF,  1'b1, 1,   1,   0,  1'b0, 2};
        tbl[2] = '{1'b0, 32'h10C, 32'h0,        4'h0,  1'b1, 1,   1,   5,  1'b0, 7};
        tbl[3] = '{1'b1, 32'h200, 32'hA5A5A5A5, 4'h5,  1'b1, 3,   1,   0,  1'b0, 4};
        tbl[4] = '{1'b1, 32'h300, 32'hCAFEF00D, 4'hF,  1'b0, 1,   1,   0,  1'b1, 1};
        tbl[5] = '{1'b0, 32'h002, 32'h0,        4'h0,  1'b1, 1,   1,   1,  1'b1, 1};
        tbl[6] = '{1'b0, 32'h200, 32'h0,        4'h0,  1'b1, 2,   1,   1,  1'b0, 4};
        tbl[7] = '{1'b1, 32'h104, 32'h11223344, 4'h8,  1'b1, 1,   4,   0,  1'b0, 5};
        tbl[8] = '{1'b0, 32'h104, 32'h0,        4'h0,  1'b1, 1,   1,   1,  1'b0, 3};
        for (int i = 0; i < 9; i++)
            apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, tbl[i].calib,
                     tbl[i].cmd_rdy, tbl[i].wdf_rdy, tbl[i].rd_dly, tbl[i].exp_err, tbl[i].exp_lat);
        check("read_lane3_value", prdata_o, 32'h11ADBEEF);

        // Reset while waiting for read data, then a stale return must be ignored.
        init_calib_complete_i = 1'b1;
        paddr_i = 32'h10C;
        pwrite_i = 1'b0;
        psel_i = 1'b1;
        penable_i = 1'b0;
        step();
        penable_i = 1'b1;
        app_rdy_i = 1'b1;
        step();
        step();
        preset_i = 1'b1;
        step();
        check("reset_mid_outputs", {pready_o, pslverr_o, app_en_o, app_wdf_wren_o, app_wdf_end_o,
                                    app_cmd_o, app_addr_o, prdata_o, app_wdf_mask_o}, '0);
        check("reset_mid_wdf_data", app_wdf_data_o, '0);
        preset_i = 1'b0;
        psel_i = 1'b0;
        penable_i = 1'b0;
        app_rdy_i = 1'b0;
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i = {32'h87654321, 96'h0};
        step();
        step();
        app_rd_data_valid_i = 1'b0;
        check("stale_valid_ignored", {pready_o, prdata_o}, '0);
        prdata_exp = '0;
        apb_xfer(1'b1, 32'h108, 32'h0BADF00D, 4'hF, 1'b1, 1, 1, 0, 1'b0, 2);
        apb_xfer(1'b0, 32'h108, 32'h0, 4'h0, 1'b1, 1, 1, 2, 1'b0, 4);

`ifdef APB_MIG_TIMEOUT_EN
        apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1000, 1000, 1, 1'b1, TMO + 1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic        wr, calib, err;
            logic [31:0] addr;
            int          c, w, d;
            wr    = 1'($urandom % 2);
            addr  = 32'($urandom_range(0, 63)) * 4;
            if ($urandom % 8 == 0) addr[1:0] = 2'($urandom_range(1, 3));
            calib = ($urandom % 8) != 0;
            c     = $urandom_range(0, 4);
            w     = $urandom_range(0, 4);
            d     = $urandom_range(1, 4);
            err   = !calib || (addr[1:0] != 2'b00);
            apb_xfer(wr, addr, $urandom, 4'($urandom), calib, c, w, d, err,
                     model_lat(wr, err, c, w, d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
